hazard_control: RTL
===================

HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The block SHALL have exactly one clock and one reset; Reset is asynchronous and active-low (asserted when 0).
REQ-002 Clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous active-low reset.
REQ-004 IdRs, IdRt  in  5 each  source register fields of the instruction in decode; IdUsesRt  in  1  decode instruction reads Rt.
REQ-005 ExRs, ExRt  in  5 each  source fields in execute; ExRd  in  5  execute destination after RegDst/Jal muxing.
REQ-006 ExRegWrite, ExMemRead  in  1 each  execute-stage control.
REQ-007 MemRd  in  5; MemRegWrite  in  1  memory-stage destination and write enable.
REQ-008 WbRd  in  5; WbRegWrite  in  1  writeback-stage destination and write enable.
REQ-009 IdJump  in  1  j/jal in decode; ExJr  in  1  jr in execute; MemBranchTaken  in  1  Branch AND Zero in memory stage.
REQ-010 CountClear  in  1  synchronous clear of both counters.
REQ-011 PCWrite, FDWrite  out  1 each  enables for PC and Fetch_To_Decode register.
REQ-012 FDFlush, DEFlush, EMFlush  out  1 each  bubble-insert for the three pipeline registers.
REQ-013 ForwardA, ForwardB  out  2 each  ALU operand select: 00 register file, 10 memory-stage ALU result, 01 writeback data.
REQ-014 State  out  2  current FSM state; StallCycles, FlushEvents  out  16 each  performance counters.

Function
REQ-015 FSM states SHALL be BOOT, RUN and STALL.
REQ-016 BOOT SHALL last exactly 2 cycles after Reset deasserts, driving PCWrite=0, FDWrite=0, FDFlush=DEFlush=EMFlush=1, then go to RUN.
REQ-017 Load-use hazard = ExMemRead & ExRd!=0 & (ExRd==IdRs | (IdUsesRt & ExRd==IdRt)).
REQ-018 In RUN with load-use and no higher-priority event, same cycle (Mealy): PCWrite=0, FDWrite=0, DEFlush=1; next state STALL.
REQ-019 STALL SHALL last one cycle with load-use detection suppressed, then return to RUN; flush events in STALL are still honoured.
REQ-020 Priority, highest first: MemBranchTaken (FDFlush=DEFlush=EMFlush=1), ExJr (FDFlush=DEFlush=1), load-use stall, IdJump (FDFlush=1).
REQ-021 A flush coinciding with load-use SHALL cancel the stall: PCWrite=FDWrite=1, state stays/returns RUN.
REQ-022 With no event, PCWrite=FDWrite=1 and all flushes 0.
REQ-023 ForwardA SHALL be 10 if MemRegWrite & MemRd!=0 & MemRd==ExRs, else 01 if WbRegWrite & WbRd!=0 & WbRd==ExRs, else 00; ForwardB identical using ExRt; forwarding is combinational and active in all states except BOOT (00).
REQ-024 StallCycles SHALL increment once per load-use stall cycle; FlushEvents once per cycle with any RUN/STALL-state flush; both saturate at 16'hFFFF.
REQ-025 CountClear SHALL zero both counters on the next edge, taking precedence over increment in that cycle.
REQ-026 Register $0 SHALL never trigger a stall or forwarding.

Reset
REQ-027 Reset low SHALL immediately force State=BOOT, boot counter 0, counters 0, PCWrite=FDWrite=0, all flushes 1, ForwardA=ForwardB=00.
REQ-028 Reset asserted mid-STALL or mid-flush SHALL abort it; no partial count survives.

Structure
REQ-029 State encodings (BOOT=00, RUN=01, STALL=10), forward-select codes and REG_ZERO SHALL live in shared package hazard_pkg.
REQ-030 Forwarding compare SHALL be one sub-module, forward_select, instantiated twice (A, B).

Verification
REQ-031 Reset release -> 2 cycles PCWrite=0 and all flushes 1, State 00, then State 01.
REQ-032 lw to $8 in EX (ExMemRead=1, ExRd=8), IdRs=8 -> PCWrite=0, DEFlush=1 one cycle, State 10 then 01, StallCycles=1.
REQ-033 Same load-use plus MemBranchTaken=1 -> PCWrite=1, all three flushes 1, no STALL, FlushEvents=1, StallCycles=0.
REQ-034 MemRd=WbRd=5, both RegWrite=1, ExRs=5 -> ForwardA=10; MemRd=0 with WbRd=0, ExRt=0 -> ForwardB=00.
REQ-035 70000 consecutive stall cycles -> StallCycles holds 16'hFFFF; CountClear pulse -> 0.
REQ-036 Reset low during STALL -> outputs at REQ-027 values within the same cycle, State 00.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM state
// encodings, forwarding select codes and the saturating counter helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10
  } state_e;

  localparam logic [1:0]  FWD_REG  = 2'b00;
  localparam logic [1:0]  FWD_MEM  = 2'b10;
  localparam logic [1:0]  FWD_WB   = 2'b01;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;
  localparam logic        BOOT_LAST = 1'b1;

  // Counters stick at full scale rather than wrapping.
  function automatic logic [15:0] satInc(input logic [15:0] value);
    return (value == CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/forward_select.sv
// One ALU operand forwarding mux select: memory stage wins over writeback,
// and register $0 never forwards.
module forward_select
  import hazard_pkg::*;
(
  input  logic [4:0] srcReg,
  input  logic [4:0] memRd,
  input  logic       memRegWrite,
  input  logic [4:0] wbRd,
  input  logic       wbRegWrite,
  input  logic       enable,
  output logic [1:0] fwdSel
);

  // Priority compare of the source field against the two younger writers.
  always_comb begin
    fwdSel = FWD_REG;
    if (!enable) begin
      fwdSel = FWD_REG;
    end else if (memRegWrite && (memRd != REG_ZERO) && (memRd == srcReg)) begin
      fwdSel = FWD_MEM;
    end else if (wbRegWrite && (wbRd != REG_ZERO) && (wbRd == srcReg)) begin
      fwdSel = FWD_WB;
    end else begin
      fwdSel = FWD_REG;
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard controller: boot sequencing, load-use stall, control-flow
// flush priority, operand forwarding and saturating performance counters.
module hazard_control
  import hazard_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRt,
  input  logic [4:0]  ExRs,
  input  logic [4:0]  ExRt,
  input  logic [4:0]  ExRd,
  input  logic        ExRegWrite,
  input  logic        ExMemRead,
  input  logic [4:0]  MemRd,
  input  logic        MemRegWrite,
  input  logic [4:0]  WbRd,
  input  logic        WbRegWrite,
  input  logic        IdJump,
  input  logic        ExJr,
  input  logic        MemBranchTaken,
  input  logic        CountClear,
  output logic        PCWrite,
  output logic        FDWrite,
  output logic        FDFlush,
  output logic        DEFlush,
  output logic        EMFlush,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic [1:0]  State,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushEvents
);

  state_e      stateR;
  logic        bootCntR;
  logic [15:0] stallCntR;
  logic [15:0] flushCntR;

  logic activeS;
  logic loadUseS;
  logic stallTakenS;
  logic flushEvS;

  // ExRegWrite is part of the stage interface but the destination mux already folds it in.
  logic unusedS;
  assign unusedS = ExRegWrite;

  assign activeS = (stateR == RUN) || (stateR == STALL);

  // Load-use is only looked for in RUN; the STALL cycle already covers it.
  assign loadUseS = (stateR == RUN) && ExMemRead && (ExRd != REG_ZERO) &&
                    ((ExRd == IdRs) || (IdUsesRt && (ExRd == IdRt)));

  // Mealy pipeline control with flush priority branch > jr > stall > jump.
  always_comb begin
    PCWrite     = 1'b1;
    FDWrite     = 1'b1;
    FDFlush     = 1'b0;
    DEFlush     = 1'b0;
    EMFlush     = 1'b0;
    stallTakenS = 1'b0;
    flushEvS    = 1'b0;
    if (!activeS) begin
      PCWrite = 1'b0;
      FDWrite = 1'b0;
      FDFlush = 1'b1;
      DEFlush = 1'b1;
      EMFlush = 1'b1;
    end else if (MemBranchTaken) begin
      FDFlush  = 1'b1;
      DEFlush  = 1'b1;
      EMFlush  = 1'b1;
      flushEvS = 1'b1;
    end else if (ExJr) begin
      FDFlush  = 1'b1;
      DEFlush  = 1'b1;
      flushEvS = 1'b1;
    end else if (loadUseS) begin
      PCWrite     = 1'b0;
      FDWrite     = 1'b0;
      DEFlush     = 1'b1;
      stallTakenS = 1'b1;
    end else if (IdJump) begin
      FDFlush  = 1'b1;
      flushEvS = 1'b1;
    end else begin
      PCWrite = 1'b1;
      FDWrite = 1'b1;
    end
  end

  // State sequencing: two boot cycles, then RUN with one-cycle STALL excursions.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateR   <= BOOT;
      bootCntR <= 1'b0;
    end else begin
      case (stateR)
        BOOT: begin
          if (bootCntR == BOOT_LAST) begin
            stateR <= RUN;
          end else begin
            bootCntR <= bootCntR + 1'b1;
          end
        end
        RUN:     stateR <= stallTakenS ? STALL : RUN;
        STALL:   stateR <= RUN;
        default: begin
          stateR   <= BOOT;
          bootCntR <= 1'b0;
        end
      endcase
    end
  end

  // Performance counters; a clear request beats any increment in the same cycle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stallCntR <= 16'd0;
      flushCntR <= 16'd0;
    end else if (CountClear) begin
      stallCntR <= 16'd0;
      flushCntR <= 16'd0;
    end else begin
      if (stallTakenS) stallCntR <= satInc(stallCntR);
      if (flushEvS)    flushCntR <= satInc(flushCntR);
    end
  end

  forward_select uFwdA (
    .srcReg      (ExRs),
    .memRd       (MemRd),
    .memRegWrite (MemRegWrite),
    .wbRd        (WbRd),
    .wbRegWrite  (WbRegWrite),
    .enable      (activeS),
    .fwdSel      (ForwardA)
  );

  forward_select uFwdB (
    .srcReg      (ExRt),
    .memRd       (MemRd),
    .memRegWrite (MemRegWrite),
    .wbRd        (WbRd),
    .wbRegWrite  (WbRegWrite),
    .enable      (activeS),
    .fwdSel      (ForwardB)
  );

  assign State       = stateR;
  assign StallCycles = stallCntR;
  assign FlushEvents = flushCntR;

endmodule
